// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control path: FSM states, opcodes,
// ALU_op codes and datapath mux select values, plus the packed control word.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_WB_MEM   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_EXEC_I   = 4'd8,
        S_WB_I     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Must match the ALU control decoder downstream.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
    } ctrl_word_t;

    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_R) || (op == OP_ADDIU) || (op == OP_SLTI) ||
               (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Moore decode of FSM state into the datapath control word; only the FETCH
// strobes look at mem_ready, and only EXEC_I / DECODE look at the opcode.
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  state_t      i_state,
    input  logic [5:0]  i_op,
    input  logic        i_mem_ready,
    output ctrl_word_t  o_ctrl,
    output logic        o_illegal_op
);

    always_comb begin
        o_ctrl       = '0;
        o_illegal_op = 1'b0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = SRCB_IMM_SH2;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_illegal_op     = !is_known_op(i_op);
            end
            S_MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            S_WB_MEM: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            S_EXEC_R: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REG;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_WB_ALU: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_EXEC_I: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = (i_op == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
            end
            S_WB_I: begin
                o_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_REG;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle CPU: instruction sequencing, memory
// wait/timeout tracking and the retired-instruction counter.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALU_op,
    output logic             illegal_op,
    output logic             bus_err,
    output logic [CNT_W-1:0] instr_retired,
    output state_t           o_state
);

    localparam int             WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_TIMEOUT - 1);

    state_t             r_state;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]   r_retired;
    ctrl_word_t         w_ctrl;
    logic               w_illegal;
    logic               w_wait_state;
    logic               w_timeout;
    logic               w_retire;
    logic               w_unused_zero;

    // Zero feeds the PC write-enable in the datapath (PCWriteCond & Zero), not the FSM.
    assign w_unused_zero = Zero;

    ctrl_out_decode u_decode (
        .i_state      (r_state),
        .i_op         (Op),
        .i_mem_ready  (mem_ready),
        .o_ctrl       (w_ctrl),
        .o_illegal_op (w_illegal)
    );

    // Memory handshake: a request is held for as long as the state keeps it;
    // mem_ready high in a cycle completes it on that edge, and wins over timeout.
    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_timeout    = w_wait_state && !mem_ready && (r_wait_cnt == LAST_WAIT);
    assign w_retire     = (r_state == S_WB_MEM) || (r_state == S_WB_ALU) || (r_state == S_WB_I) ||
                          (r_state == S_BRANCH) || (r_state == S_JUMP) ||
                          ((r_state == S_MEM_WR) && mem_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_retired  <= '0;
        end else begin
            if (w_wait_state && !mem_ready && !w_timeout)
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            else
                r_wait_cnt <= '0;
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
            case (r_state)
                S_FETCH:    if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        OP_LW, OP_SW:      r_state <= S_MEM_ADDR;
                        OP_R:              r_state <= S_EXEC_R;
                        OP_ADDIU, OP_SLTI: r_state <= S_EXEC_I;
                        OP_BEQ:            r_state <= S_BRANCH;
                        OP_J:              r_state <= S_JUMP;
                        default:           r_state <= S_FETCH;
                    endcase
                end
                S_MEM_ADDR: r_state <= (Op == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: begin
                    if (mem_ready)      r_state <= S_WB_MEM;
                    else if (w_timeout) r_state <= S_FETCH;
                end
                S_MEM_WR:   if (mem_ready || w_timeout) r_state <= S_FETCH;
                S_EXEC_R:   r_state <= S_WB_ALU;
                S_EXEC_I:   r_state <= S_WB_I;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    assign PCWrite       = !reset && w_ctrl.pc_write;
    assign PCWriteCond   = !reset && w_ctrl.pc_write_cond;
    assign IorD          = !reset && w_ctrl.iord;
    assign MemRead       = !reset && w_ctrl.mem_read;
    assign MemWrite      = !reset && w_ctrl.mem_write;
    assign IRWrite       = !reset && w_ctrl.ir_write;
    assign RegDst        = !reset && w_ctrl.reg_dst;
    assign MemtoReg      = !reset && w_ctrl.mem_to_reg;
    assign RegWrite      = !reset && w_ctrl.reg_write;
    assign ALUSrcA       = !reset && w_ctrl.alu_src_a;
    assign ALUSrcB       = reset ? 2'b00 : w_ctrl.alu_src_b;
    assign PCSource      = reset ? 2'b00 : w_ctrl.pc_source;
    assign ALU_op        = reset ? 2'b00 : w_ctrl.alu_op;
    assign illegal_op    = !reset && w_illegal;
    assign bus_err       = !reset && w_timeout;
    assign instr_retired = reset ? '0 : r_retired;
    assign o_state       = reset ? S_FETCH : r_state;

endmodule
